// File: rtl/iq_collapse_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_collapse_param_pkg
// Description : Shared types and default sizing for the collapsing issue
//               queue (PRF tag type, default parameters, slot record).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package iq_collapse_param_pkg;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_ENQ_W     = 2;
   localparam int DEF_ISS_W     = 2;
   localparam int DEF_WAKE_W    = 4;
   localparam int DEF_TAG_W     = 6;
   localparam int DEF_PAYLOAD_W = 128;

   // Physical register file tag
   typedef logic [DEF_TAG_W-1:0] prf_num_t;

   // One queue slot at default widths; the top re-declares it at its own widths
   typedef struct packed {
      logic                     valid;
      logic [DEF_PAYLOAD_W-1:0] payload;
      prf_num_t                 src0;
      prf_num_t                 src1;
      logic                     r0;
      logic                     r1;
      prf_num_t                 dst;
      logic                     dst_we;
   } iq_slot_t;

endpackage
`default_nettype wire

// File: rtl/iq_collapse_param_slot_wake.sv
`default_nettype none
// ============================================================================
// Module      : iq_slot_wake
// Description : Source-operand wakeup for one entry: ORs any tag match from
//               the valid result broadcasts into the entry's ready bits.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module iq_slot_wake
   import iq_collapse_param_pkg::*;
#(
   parameter int TAG_W  = DEF_TAG_W,
   parameter int WAKE_W = DEF_WAKE_W
) (
   input  logic [TAG_W-1:0]              src0,
   input  logic [TAG_W-1:0]              src1,
   input  logic                          r0_in,
   input  logic                          r1_in,
   input  logic [WAKE_W-1:0]             wake_valid,
   input  logic [WAKE_W-1:0][TAG_W-1:0]  wake_tag,
   output logic                          r0_out,
   output logic                          r1_out
);

   // Sticky ready bits: a broadcast can only set them, never clear them
   always_comb begin
      r0_out = r0_in;
      r1_out = r1_in;
      for (int w = 0; w < WAKE_W; w++) begin
         if (wake_valid[w] && (wake_tag[w] == src0)) r0_out = 1'b1;
         if (wake_valid[w] && (wake_tag[w] == src1)) r1_out = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/iq_collapse_param.sv
`default_nettype none
// ============================================================================
// Module      : iq_collapse_param
// Description : Age-ordered collapsing issue queue. Issues the ISS_W oldest
//               ready entries, removes fired ones and compacts survivors
//               toward slot 0, appending new micro-ops above them.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module iq_collapse_param
   import iq_collapse_param_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ENQ_W     = DEF_ENQ_W,
   parameter int ISS_W     = DEF_ISS_W,
   parameter int WAKE_W    = DEF_WAKE_W,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [ENQ_W-1:0]                    enq_valid,
   input  logic [ENQ_W-1:0][PAYLOAD_W-1:0]     enq_payload,
   input  logic [ENQ_W-1:0][TAG_W-1:0]         enq_src0,
   input  logic [ENQ_W-1:0][TAG_W-1:0]         enq_src1,
   input  logic [ENQ_W-1:0]                    enq_src0_rdy,
   input  logic [ENQ_W-1:0]                    enq_src1_rdy,
   input  logic [ENQ_W-1:0][TAG_W-1:0]         enq_dst,
   input  logic [ENQ_W-1:0]                    enq_dst_we,
   output logic                                enq_ready,
   input  logic [WAKE_W-1:0]                   wake_valid,
   input  logic [WAKE_W-1:0][TAG_W-1:0]        wake_tag,
   output logic [ISS_W-1:0]                    iss_valid,
   input  logic [ISS_W-1:0]                    iss_ready,
   output logic [ISS_W-1:0][PAYLOAD_W-1:0]     iss_payload,
   output logic [ISS_W-1:0][TAG_W-1:0]         iss_dst,
   output logic [ISS_W-1:0]                    iss_dst_we,
   output logic [$clog2(DEPTH+1)-1:0]          occupancy
);

   localparam int C_CNT_W = $clog2(DEPTH + 1);
   localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [TAG_W-1:0] tag_t;
   typedef struct packed {
      logic                 valid;
      logic [PAYLOAD_W-1:0] payload;
      tag_t                 src0;
      tag_t                 src1;
      logic                 r0;
      logic                 r1;
      tag_t                 dst;
      logic                 dst_we;
   } slot_t;

   slot_t               r_slot [DEPTH];
   logic [C_CNT_W-1:0]  r_occ;

   logic [DEPTH-1:0]    w_rdy;
   logic [DEPTH-1:0]    w_wr0;
   logic [DEPTH-1:0]    w_wr1;
   logic [DEPTH-1:0]    w_slot_fire;
   logic [C_CNT_W-1:0]  w_rank  [DEPTH];
   logic [C_CNT_W-1:0]  w_below [DEPTH];
   logic [ENQ_W-1:0]    w_lr0;
   logic [ENQ_W-1:0]    w_lr1;
   logic [C_CNT_W-1:0]  w_lane_off [ENQ_W];
   logic [C_IDX_W-1:0]  w_sel_idx  [ISS_W];
   logic [ISS_W-1:0]    w_sel_v;
   logic [ISS_W-1:0]    w_fire;
   logic [C_CNT_W-1:0]  w_nfire;
   logic [C_CNT_W-1:0]  w_nenq;
   logic [C_CNT_W-1:0]  w_base;
   slot_t               w_next [DEPTH];

   // Number of set bits of v strictly below position pos
   function automatic logic [C_CNT_W-1:0] cnt_below(input logic [DEPTH-1:0] v, input int pos);
      logic [C_CNT_W-1:0] c;
      c = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (j < pos) c = c + C_CNT_W'(v[j]);
      end
      return c;
   endfunction

   // Per-slot wakeup, ready detect and the two prefix counts (select rank, collapse distance)
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      iq_slot_wake #(.TAG_W(TAG_W), .WAKE_W(WAKE_W)) u_wake (
         .src0       (r_slot[i].src0),
         .src1       (r_slot[i].src1),
         .r0_in      (r_slot[i].r0),
         .r1_in      (r_slot[i].r1),
         .wake_valid (wake_valid),
         .wake_tag   (wake_tag),
         .r0_out     (w_wr0[i]),
         .r1_out     (w_wr1[i])
      );
      assign w_rdy[i]   = r_slot[i].valid & r_slot[i].r0 & r_slot[i].r1;
      assign w_rank[i]  = cnt_below(w_rdy, i);
      assign w_below[i] = cnt_below(w_slot_fire, i);
   end

   // Same-cycle wakeup bypass for entries being enqueued
   for (genvar l = 0; l < ENQ_W; l++) begin : g_lane
      iq_slot_wake #(.TAG_W(TAG_W), .WAKE_W(WAKE_W)) u_wake (
         .src0       (enq_src0[l]),
         .src1       (enq_src1[l]),
         .r0_in      (enq_src0_rdy[l]),
         .r1_in      (enq_src1_rdy[l]),
         .wake_valid (wake_valid),
         .wake_tag   (wake_tag),
         .r0_out     (w_lr0[l]),
         .r1_out     (w_lr1[l])
      );
   end

   // Select: channel k takes the ready slot that has exactly k older ready slots
   always_comb begin
      w_sel_v = '0;
      for (int k = 0; k < ISS_W; k++) w_sel_idx[k] = '0;
      for (int k = 0; k < ISS_W; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i] && (w_rank[i] == C_CNT_W'(k))) begin
               w_sel_v[k]   = 1'b1;
               w_sel_idx[k] = C_IDX_W'(i);
            end
         end
      end
   end

   // Issue channel outputs come only from slot registers; fire maps back onto slots
   always_comb begin
      iss_valid   = w_sel_v;
      iss_payload = '0;
      iss_dst     = '0;
      iss_dst_we  = '0;
      w_fire      = w_sel_v & iss_ready;
      w_nfire     = '0;
      w_slot_fire = '0;
      for (int k = 0; k < ISS_W; k++) begin
         iss_payload[k] = r_slot[w_sel_idx[k]].payload;
         iss_dst[k]     = r_slot[w_sel_idx[k]].dst;
         iss_dst_we[k]  = r_slot[w_sel_idx[k]].dst_we;
         w_nfire        = w_nfire + C_CNT_W'(w_fire[k]);
         for (int i = 0; i < DEPTH; i++) begin
            if (w_fire[k] && (w_sel_idx[k] == C_IDX_W'(i))) w_slot_fire[i] = 1'b1;
         end
      end
   end

   // Lane compaction: each valid lane's offset above the enqueue base
   always_comb begin
      w_nenq = '0;
      for (int l = 0; l < ENQ_W; l++) begin
         w_lane_off[l] = w_nenq;
         w_nenq        = w_nenq + C_CNT_W'(enq_valid[l]);
      end
   end

   // Room check uses the registered count only; same-cycle fires are not credited
   assign enq_ready = (C_CNT_W'(DEPTH) - r_occ) >= C_CNT_W'(ENQ_W);
   assign w_base    = r_occ - w_nfire;
   assign occupancy = r_occ;

   // Next slot image: gather collapsed survivors, then place new lanes above them
   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         w_next[j] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (r_slot[i].valid && !w_slot_fire[i] &&
                ((C_CNT_W'(i) - w_below[i]) == C_CNT_W'(j))) begin
               w_next[j]    = r_slot[i];
               w_next[j].r0 = w_wr0[i];
               w_next[j].r1 = w_wr1[i];
            end
         end
         for (int l = 0; l < ENQ_W; l++) begin
            if (enq_ready && enq_valid[l] && ((w_base + w_lane_off[l]) == C_CNT_W'(j))) begin
               w_next[j].valid   = 1'b1;
               w_next[j].payload = enq_payload[l];
               w_next[j].src0    = enq_src0[l];
               w_next[j].src1    = enq_src1[l];
               w_next[j].r0      = w_lr0[l];
               w_next[j].r1      = w_lr1[l];
               w_next[j].dst     = enq_dst[l];
               w_next[j].dst_we  = enq_dst_we[l];
            end
         end
      end
   end

   // Slot and count registers; flush outranks enqueue and fire
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= '0;
         for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      end else if (flush) begin
         r_occ <= '0;
         for (int i = 0; i < DEPTH; i++) r_slot[i].valid <= 1'b0;
      end else begin
         r_occ <= r_occ - w_nfire + (enq_ready ? w_nenq : '0);
         for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_next[i];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iq_collapse_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_collapse_param
// Description : Self-checking bench for iq_collapse_param: fill table,
//               directed corner sequences and random traffic against an
//               age-ordered list model of the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_collapse_param;

   localparam int DEPTH  = 8;
   localparam int ENQ_W  = 2;
   localparam int ISS_W  = 2;
   localparam int WAKE_W = 4;
   localparam int TAG_W  = 6;
   localparam int PW     = 128;
   localparam int CW     = $clog2(DEPTH + 1);

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          flush;
   logic [ENQ_W-1:0]              enq_valid;
   logic [ENQ_W-1:0][PW-1:0]      enq_payload;
   logic [ENQ_W-1:0][TAG_W-1:0]   enq_src0, enq_src1, enq_dst;
   logic [ENQ_W-1:0]              enq_src0_rdy, enq_src1_rdy, enq_dst_we;
   logic                          enq_ready;
   logic [WAKE_W-1:0]             wake_valid;
   logic [WAKE_W-1:0][TAG_W-1:0]  wake_tag;
   logic [ISS_W-1:0]              iss_valid, iss_ready, iss_dst_we;
   logic [ISS_W-1:0][PW-1:0]      iss_payload;
   logic [ISS_W-1:0][TAG_W-1:0]   iss_dst;
   logic [CW-1:0]                 occupancy;

   iq_collapse_param #(
      .DEPTH(DEPTH), .ENQ_W(ENQ_W), .ISS_W(ISS_W), .WAKE_W(WAKE_W),
      .TAG_W(TAG_W), .PAYLOAD_W(PW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_payload(enq_payload),
      .enq_src0(enq_src0), .enq_src1(enq_src1),
      .enq_src0_rdy(enq_src0_rdy), .enq_src1_rdy(enq_src1_rdy),
      .enq_dst(enq_dst), .enq_dst_we(enq_dst_we), .enq_ready(enq_ready),
      .wake_valid(wake_valid), .wake_tag(wake_tag),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
      .iss_dst(iss_dst), .iss_dst_we(iss_dst_we), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Reference model: age-ordered list of resident entries
   typedef struct {
      logic [PW-1:0]    pl;
      logic [TAG_W-1:0] s0, s1, dst;
      logic             r0, r1, we;
   } ment_t;

   typedef struct {
      logic [ENQ_W-1:0] ev;
      logic [CW-1:0]    occ;
      logic             er;
      logic [ISS_W-1:0] iv;
   } vec_t;

   ment_t         mq[$];
   int            sel[$];
   int            checks   = 0;
   int            failures = 0;
   int unsigned   uid      = 0;
   logic [PW-1:0] p [8];
   logic [PW-1:0] dummy;
   vec_t          tbl [6];

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit woken(input logic [TAG_W-1:0] t);
      for (int w = 0; w < WAKE_W; w++) if (wake_valid[w] && wake_tag[w] == t) return 1'b1;
      return 1'b0;
   endfunction

   // Compare DUT outputs with the model: oldest ready entries go out first
   task automatic model_check();
      sel.delete();
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].r0 && mq[i].r1 && sel.size() < ISS_W) sel.push_back(i);
      for (int k = 0; k < ISS_W; k++) begin
         chk("m_iss_valid", PW'(iss_valid[k]), PW'(k < sel.size()));
         if (k < sel.size()) begin
            chk("m_iss_payload", iss_payload[k], mq[sel[k]].pl);
            chk("m_iss_dst", PW'(iss_dst[k]), PW'(mq[sel[k]].dst));
            chk("m_iss_dst_we", PW'(iss_dst_we[k]), PW'(mq[sel[k]].we));
         end
      end
      chk("m_occupancy", PW'(occupancy), PW'(mq.size()));
      chk("m_enq_ready", PW'(enq_ready), PW'((DEPTH - mq.size()) >= ENQ_W));
   endtask

   task automatic model_advance();
      ment_t nq[$];
      ment_t e;
      bit    er;
      bit    fired;
      er = (DEPTH - mq.size()) >= ENQ_W;
      if (flush) begin
         mq.delete();
         return;
      end
      for (int i = 0; i < mq.size(); i++) begin
         fired = 1'b0;
         for (int k = 0; k < sel.size(); k++) if (sel[k] == i && iss_ready[k]) fired = 1'b1;
         if (!fired) begin
            e    = mq[i];
            e.r0 = e.r0 | woken(e.s0);
            e.r1 = e.r1 | woken(e.s1);
            nq.push_back(e);
         end
      end
      if (er) begin
         for (int l = 0; l < ENQ_W; l++) begin
            if (enq_valid[l]) begin
               e.pl  = enq_payload[l];
               e.s0  = enq_src0[l];
               e.s1  = enq_src1[l];
               e.dst = enq_dst[l];
               e.we  = enq_dst_we[l];
               e.r0  = enq_src0_rdy[l] | woken(enq_src0[l]);
               e.r1  = enq_src1_rdy[l] | woken(enq_src1[l]);
               nq.push_back(e);
            end
         end
      end
      mq = nq;
   endtask

   // One cycle: check against the model, advance it, cross the edge
   task automatic step();
      #1;
      model_check();
      model_advance();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      flush        = 1'b0;
      enq_valid    = '0;
      enq_payload  = '0;
      enq_src0     = '0;
      enq_src1     = '0;
      enq_src0_rdy = '0;
      enq_src1_rdy = '0;
      enq_dst      = '0;
      enq_dst_we   = '0;
      wake_valid   = '0;
      wake_tag     = '0;
      iss_ready    = '0;
   endtask

   task automatic set_lane(input int l, input bit r0, input bit r1,
                           input logic [TAG_W-1:0] s0, input logic [TAG_W-1:0] s1,
                           output logic [PW-1:0] pl);
      uid++;
      pl              = {$urandom(), $urandom(), $urandom(), uid};
      enq_valid[l]    = 1'b1;
      enq_payload[l]  = pl;
      enq_src0[l]     = s0;
      enq_src1[l]     = s1;
      enq_src0_rdy[l] = r0;
      enq_src1_rdy[l] = r1;
      enq_dst[l]      = TAG_W'(uid);
      enq_dst_we[l]   = uid[0];
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{2'b11, CW'(0), 1'b1, 2'b00};
      tbl[1] = '{2'b11, CW'(2), 1'b1, 2'b11};
      tbl[2] = '{2'b11, CW'(4), 1'b1, 2'b11};
      tbl[3] = '{2'b11, CW'(6), 1'b1, 2'b11};
      tbl[4] = '{2'b11, CW'(8), 1'b0, 2'b11};
      tbl[5] = '{2'b00, CW'(8), 1'b0, 2'b11};

      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_iss_valid", PW'(iss_valid), PW'(0));
      chk("rst_occupancy", PW'(occupancy), PW'(0));
      chk("rst_enq_ready", PW'(enq_ready), PW'(1));
      rst = 1'b0;

      // Hold 5 entries, then assert reset asynchronously mid-cycle
      set_lane(0, 1, 1, 6'd1, 6'd2, dummy); set_lane(1, 1, 1, 6'd1, 6'd2, dummy); step();
      set_lane(0, 1, 1, 6'd1, 6'd2, dummy); set_lane(1, 1, 1, 6'd1, 6'd2, dummy); step();
      idle(); set_lane(0, 1, 1, 6'd1, 6'd2, dummy); step();
      idle();
      chk("pre_rst_occupancy", PW'(occupancy), PW'(5));
      rst = 1'b1;
      #1;
      chk("async_rst_occupancy", PW'(occupancy), PW'(0));
      chk("async_rst_iss_valid", PW'(iss_valid), PW'(0));
      chk("async_rst_enq_ready", PW'(enq_ready), PW'(1));
      mq.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Fill table: two ready ops per cycle, fifth attempt is dropped
      for (int t = 0; t < 6; t++) begin
         idle();
         for (int l = 0; l < ENQ_W; l++)
            if (tbl[t].ev[l]) set_lane(l, 1, 1, 6'd3, 6'd4, dummy);
         chk("fill_occupancy", PW'(occupancy), PW'(tbl[t].occ));
         chk("fill_enq_ready", PW'(enq_ready), PW'(tbl[t].er));
         chk("fill_iss_valid", PW'(iss_valid), PW'(tbl[t].iv));
         step();
      end

      // Flush while two entries are issuing
      idle(); iss_ready = 2'b11; flush = 1'b1;
      chk("flush_cycle_iss_valid", PW'(iss_valid), PW'(2'b11));
      step();
      idle();
      chk("post_flush_occupancy", PW'(occupancy), PW'(0));
      chk("post_flush_iss_valid", PW'(iss_valid), PW'(0));
      chk("post_flush_enq_ready", PW'(enq_ready), PW'(1));

      // Age order: readiness 0,1,0,1
      set_lane(0, 0, 1, 6'd20, 6'd2, p[0]); set_lane(1, 1, 1, 6'd3, 6'd4, p[1]); step();
      idle(); set_lane(0, 0, 1, 6'd20, 6'd2, p[2]); set_lane(1, 1, 1, 6'd3, 6'd4, p[3]); step();
      idle(); iss_ready = 2'b11;
      chk("age_iss_valid", PW'(iss_valid), PW'(2'b11));
      chk("age_ch0", iss_payload[0], p[1]);
      chk("age_ch1", iss_payload[1], p[3]);
      step();
      idle(); wake_valid[0] = 1'b1; wake_tag[0] = 6'd20;
      chk("age_occupancy", PW'(occupancy), PW'(2));
      step();
      idle(); iss_ready = 2'b11;
      chk("age_kept_ch0", iss_payload[0], p[0]);
      chk("age_kept_ch1", iss_payload[1], p[2]);
      step();

      // Backpressure: only channel 1 accepted
      idle(); set_lane(0, 1, 1, 6'd3, 6'd4, p[0]); set_lane(1, 1, 1, 6'd3, 6'd4, p[1]); step();
      idle(); iss_ready = 2'b10;
      chk("bp_iss_valid", PW'(iss_valid), PW'(2'b11));
      step();
      idle(); iss_ready = 2'b11;
      chk("bp_occupancy", PW'(occupancy), PW'(1));
      chk("bp_iss_valid_after", PW'(iss_valid), PW'(2'b01));
      chk("bp_reselect_ch0", iss_payload[0], p[0]);
      step();

      // Wake bypass: broadcast of tag 13 during enqueue
      idle(); set_lane(0, 0, 1, 6'd13, 6'd4, p[0]);
      wake_valid[2] = 1'b1; wake_tag[2] = 6'd13;
      step();
      idle(); iss_ready = 2'b11;
      chk("bypass_iss_valid", PW'(iss_valid[0]), PW'(1));
      chk("bypass_payload", iss_payload[0], p[0]);
      step();
      idle(); set_lane(0, 0, 1, 6'd13, 6'd4, p[0]); step();
      for (int c = 0; c < 3; c++) begin
         idle(); iss_ready = 2'b11;
         chk("no_bypass_iss_valid", PW'(iss_valid), PW'(0));
         step();
      end
      idle(); flush = 1'b1; step();

      // Collapse + enqueue: fire slots 0 and 4 of 6 while enqueueing 2
      idle(); set_lane(0, 1, 1, 6'd3, 6'd4, p[0]); set_lane(1, 0, 1, 6'd30, 6'd4, p[1]); step();
      idle(); set_lane(0, 0, 1, 6'd30, 6'd4, p[2]); set_lane(1, 0, 1, 6'd30, 6'd4, p[3]); step();
      idle(); set_lane(0, 1, 1, 6'd3, 6'd4, p[4]); set_lane(1, 0, 1, 6'd30, 6'd4, p[5]); step();
      idle(); iss_ready = 2'b11;
      set_lane(0, 0, 1, 6'd30, 6'd4, p[6]); set_lane(1, 0, 1, 6'd30, 6'd4, p[7]);
      chk("coll_occ_before", PW'(occupancy), PW'(6));
      chk("coll_ch0", iss_payload[0], p[0]);
      chk("coll_ch1", iss_payload[1], p[4]);
      step();
      idle(); wake_valid[1] = 1'b1; wake_tag[1] = 6'd30;
      chk("coll_occ_after", PW'(occupancy), PW'(6));
      step();
      for (int c = 0; c < 3; c++) begin
         idle(); iss_ready = 2'b11;
         chk("coll_order_ch0", iss_payload[0], (c == 0) ? p[1] : (c == 1) ? p[3] : p[6]);
         chk("coll_order_ch1", iss_payload[1], (c == 0) ? p[2] : (c == 1) ? p[5] : p[7]);
         step();
      end

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         idle();
         for (int l = 0; l < ENQ_W; l++)
            if ($urandom_range(0, 2) != 0)
               set_lane(l, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                        TAG_W'($urandom_range(1, 15)), TAG_W'($urandom_range(1, 15)), dummy);
         for (int w = 0; w < WAKE_W; w++) begin
            wake_valid[w] = ($urandom_range(0, 3) == 0);
            wake_tag[w]   = TAG_W'($urandom_range(1, 15));
         end
         iss_ready = ISS_W'($urandom());
         flush     = ($urandom_range(0, 40) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
